// File: rtl/watch_pkg.sv
// Shared watch definitions: field limits, reset time, field-select encoding and wrap helper.
// Pure declarations; no state, no latency, no backpressure.
package watch_pkg;

    localparam int CSEC_LIM = 100;
    localparam int SEC_LIM  = 60;
    localparam int MIN_LIM  = 60;
    localparam int HOUR_LIM = 24;

    localparam logic [6:0] CSEC_LAST = 7'(CSEC_LIM - 1);
    localparam logic [5:0] SEC_LAST  = 6'(SEC_LIM - 1);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_LIM - 1);
    localparam logic [4:0] HOUR_LAST = 5'(HOUR_LIM - 1);

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] csec;
    } watch_time_t;

    localparam watch_time_t RESET_TIME = '{hour: 5'd12, min: 6'd0, sec: 6'd0, csec: 7'd0};

    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HOUR = 2'd2
    } field_e;

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

    // Hour outranks minute, minute outranks second when several selects are high.
    function automatic field_e field_select(input logic set_hour, input logic set_min);
        field_e f;
        if (set_hour)
            f = FLD_HOUR;
        else if (set_min)
            f = FLD_MIN;
        else
            f = FLD_SEC;
        return f;
    endfunction

    function automatic logic [2:0] field_mask(input field_e f);
        logic [2:0] m;
        case (f)
            FLD_HOUR: m = 3'b100;
            FLD_MIN:  m = 3'b010;
            default:  m = 3'b001;
        endcase
        return m;
    endfunction

    function automatic logic [6:0] wrap_step(input logic [6:0] v, input int lim, input logic down);
        logic [6:0] last;
        logic [6:0] r;
        last = 7'(lim - 1);
        if (down)
            r = (v == 7'd0) ? last : v - 7'd1;
        else
            r = (v == last) ? 7'd0 : v + 7'd1;
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Divider: one-cycle o_tick while the count sits at DIV-1 and i_en is high; count holds when i_en is low.
// i_clear zeroes the count and suppresses the tick that cycle; no backpressure.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign o_tick = i_en && !i_clear && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (i_clear)
            cnt <= '0;
        else if (i_en)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/watch_set_dp.sv
// Watch time-of-day datapath with run/set modes, field editing and blink mask; outputs registered, 1-cycle latency.
// Pulse inputs are consumed the cycle they arrive; there is no backpressure.
module watch_set_dp
    import watch_pkg::*;
#(
    parameter int TICK_DIV    = 1_000_000,
    parameter int BLINK_TICKS = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_set_sec,
    input  logic       i_set_min,
    input  logic       i_set_hour,
    input  logic       i_up,
    input  logic       i_down,
    output logic [6:0] o_csec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic [2:0] o_blank
);

    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    watch_time_t   tm;
    watch_time_t   tm_next;
    mode_e         mode;
    mode_e         prev_mode;
    field_e        field;
    logic          resume;
    logic          run_tick;
    logic          blink_tick;
    logic          edit_any;
    logic          edit_inc;
    logic          edit_dec;
    logic          blink_restart;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_next;
    logic          blink_on;
    logic          blink_on_next;
    logic [2:0]    blank;
    logic [2:0]    blank_next;

    assign mode     = (i_set_sec || i_set_min || i_set_hour) ? MODE_SET : MODE_RUN;
    assign field    = field_select(i_set_hour, i_set_min);
    assign resume   = (mode == MODE_RUN) && (prev_mode == MODE_SET);
    assign edit_any = (mode == MODE_SET) && (i_up || i_down);
    assign edit_inc = edit_any && i_up && !i_down;
    assign edit_dec = edit_any && i_down && !i_up;

    // Blink timing is held cleared throughout RUN, so entering SET always starts visible from a fresh count.
    assign blink_restart = (mode == MODE_RUN) || edit_any;

    tick_gen #(.DIV(TICK_DIV)) u_run_div (
        .clk     (clk),
        .rst     (rst),
        .i_en    (mode == MODE_RUN),
        .i_clear (resume),
        .o_tick  (run_tick)
    );

    tick_gen #(.DIV(TICK_DIV)) u_blink_div (
        .clk     (clk),
        .rst     (rst),
        .i_en    (mode == MODE_SET),
        .i_clear (blink_restart),
        .o_tick  (blink_tick)
    );

    always_comb begin
        tm_next = tm;
        if (mode == MODE_RUN) begin
            if (resume) begin
                tm_next.csec = '0;
            end else if (run_tick) begin
                tm_next.csec = wrap_step(tm.csec, CSEC_LIM, 1'b0);
                if (tm.csec == CSEC_LAST) begin
                    tm_next.sec = 6'(wrap_step(7'(tm.sec), SEC_LIM, 1'b0));
                    if (tm.sec == SEC_LAST) begin
                        tm_next.min = 6'(wrap_step(7'(tm.min), MIN_LIM, 1'b0));
                        if (tm.min == MIN_LAST)
                            tm_next.hour = 5'(wrap_step(7'(tm.hour), HOUR_LIM, 1'b0));
                    end
                end
            end
        end else if (edit_inc || edit_dec) begin
            // Edits wrap within the selected field only; neighbours never see a carry or borrow.
            case (field)
                FLD_HOUR: tm_next.hour = 5'(wrap_step(7'(tm.hour), HOUR_LIM, edit_dec));
                FLD_MIN:  tm_next.min  = 6'(wrap_step(7'(tm.min), MIN_LIM, edit_dec));
                default:  tm_next.sec  = 6'(wrap_step(7'(tm.sec), SEC_LIM, edit_dec));
            endcase
        end
    end

    always_comb begin
        blink_cnt_next = blink_cnt;
        blink_on_next  = blink_on;
        if (blink_restart) begin
            blink_cnt_next = '0;
            blink_on_next  = 1'b0;
        end else if (blink_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_next = '0;
                blink_on_next  = !blink_on;
            end else begin
                blink_cnt_next = blink_cnt + BW'(1);
            end
        end
        blank_next = ((mode == MODE_SET) && blink_on_next) ? field_mask(field) : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tm        <= RESET_TIME;
            prev_mode <= MODE_RUN;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
            blank     <= 3'b000;
        end else begin
            tm        <= tm_next;
            prev_mode <= mode;
            blink_cnt <= blink_cnt_next;
            blink_on  <= blink_on_next;
            blank     <= blank_next;
        end
    end

    assign o_csec  = tm.csec;
    assign o_sec   = tm.sec;
    assign o_min   = tm.min;
    assign o_hour  = tm.hour;
    assign o_blank = blank;

endmodule

// File: tb/tb_watch_set_dp.sv
// Bench for watch_set_dp: directed vectors, corner sequences and random traffic against a time-of-day model.
// Small TICK_DIV/BLINK_TICKS keep every scenario short.
module tb_watch_set_dp;

    localparam int TD  = 4;
    localparam int BT  = 2;
    localparam int DAY = 24 * 60 * 60 * 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_set_sec;
    logic       i_set_min;
    logic       i_set_hour;
    logic       i_up;
    logic       i_down;
    logic [6:0] o_csec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic [2:0] o_blank;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: time as centiseconds of the day, cycles counted toward the next tick, SET cycles since blink restart.
    int         m_t;
    int         m_c;
    int         m_age;
    bit         m_prev_set;
    logic [2:0] m_blank;

    typedef struct {
        logic [2:0] sel;
        logic       up;
        logic       dn;
        int         exp_time;
        logic [2:0] exp_blank;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    watch_set_dp #(.TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_set_sec  (i_set_sec),
        .i_set_min  (i_set_min),
        .i_set_hour (i_set_hour),
        .i_up       (i_up),
        .i_down     (i_down),
        .o_csec     (o_csec),
        .o_sec      (o_sec),
        .o_min      (o_min),
        .o_hour     (o_hour),
        .o_blank    (o_blank)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_time();
        return int'(o_hour) * 1000000 + int'(o_min) * 10000 + int'(o_sec) * 100 + int'(o_csec);
    endfunction

    function automatic int model_time();
        int h, mi, s, cs;
        h  = m_t / 360000;
        mi = (m_t / 6000) % 60;
        s  = (m_t / 100) % 60;
        cs = m_t % 100;
        return h * 1000000 + mi * 10000 + s * 100 + cs;
    endfunction

    function automatic void model_reset();
        m_t        = 12 * 360000;
        m_c        = 0;
        m_age      = 0;
        m_prev_set = 1'b0;
        m_blank    = 3'b000;
    endfunction

    function automatic void model_step(input logic [2:0] sel, input logic up, input logic dn);
        int h, mi, s, cs;
        bit set;
        set = (sel != 3'b000);
        h   = m_t / 360000;
        mi  = (m_t / 6000) % 60;
        s   = (m_t / 100) % 60;
        cs  = m_t % 100;
        if (set) begin
            if (up && !dn) begin
                if (sel[2])      h  = (h + 1) % 24;
                else if (sel[1]) mi = (mi + 1) % 60;
                else             s  = (s + 1) % 60;
            end else if (dn && !up) begin
                if (sel[2])      h  = (h + 23) % 24;
                else if (sel[1]) mi = (mi + 59) % 60;
                else             s  = (s + 59) % 60;
            end
            m_t = ((h * 60 + mi) * 60 + s) * 100 + cs;
            if (up || dn) m_age = 0;
            else          m_age++;
            if (((m_age / (TD * BT)) % 2) == 1)
                m_blank = sel[2] ? 3'b100 : (sel[1] ? 3'b010 : 3'b001);
            else
                m_blank = 3'b000;
        end else begin
            if (m_prev_set) begin
                m_t = m_t - cs;
                m_c = 0;
            end else begin
                m_c++;
                if (m_c == TD) begin
                    m_c = 0;
                    m_t = (m_t + 1) % DAY;
                end
            end
            m_age   = 0;
            m_blank = 3'b000;
        end
        m_prev_set = set;
    endfunction

    task automatic cycle(input logic [2:0] sel, input logic up, input logic dn);
        i_set_hour = sel[2];
        i_set_min  = sel[1];
        i_set_sec  = sel[0];
        i_up       = up;
        i_down     = dn;
        @(posedge clk);
        model_step(sel, up, dn);
        #1;
        chk("model_time", dut_time(), model_time());
        chk("model_blank", int'(o_blank), int'(m_blank));
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        i_set_hour = 1'b0;
        i_set_min  = 1'b0;
        i_set_sec  = 1'b0;
        i_up       = 1'b0;
        i_down     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [2:0] rsel;
        int         rlen;

        vecs[0]  = '{3'b001, 1'b1, 1'b0, 12000100, 3'b000};
        vecs[1]  = '{3'b001, 1'b0, 1'b1, 12000000, 3'b000};
        vecs[2]  = '{3'b001, 1'b0, 1'b1, 12005900, 3'b000};
        vecs[3]  = '{3'b010, 1'b0, 1'b1, 12595900, 3'b000};
        vecs[4]  = '{3'b010, 1'b1, 1'b0, 12005900, 3'b000};
        vecs[5]  = '{3'b010, 1'b0, 1'b1, 12595900, 3'b000};
        vecs[6]  = '{3'b100, 1'b0, 1'b1, 11595900, 3'b000};
        vecs[7]  = '{3'b101, 1'b1, 1'b1, 11595900, 3'b000};
        vecs[8]  = '{3'b110, 1'b1, 1'b0, 12595900, 3'b000};
        vecs[9]  = '{3'b011, 1'b1, 1'b0, 12005900, 3'b000};
        vecs[10] = '{3'b011, 1'b0, 1'b1, 12595900, 3'b000};
        vecs[11] = '{3'b111, 1'b1, 1'b0, 13595900, 3'b000};

        rst        = 1'b1;
        i_set_hour = 1'b0;
        i_set_min  = 1'b0;
        i_set_sec  = 1'b0;
        i_up       = 1'b0;
        i_down     = 1'b0;
        #1;
        chk("reset_time", dut_time(), 12000000);
        chk("reset_blank", int'(o_blank), 0);

        // First tick exactly TICK_DIV cycles after release, one second after 100 ticks.
        apply_reset();
        repeat (4) cycle(3'b000, 1'b0, 1'b0);
        chk("first_tick_csec", int'(o_csec), 1);
        repeat (396) cycle(3'b000, 1'b0, 1'b0);
        chk("one_second", dut_time(), 12000100);

        apply_reset();
        foreach (vecs[i]) begin
            cycle(vecs[i].sel, vecs[i].up, vecs[i].dn);
            chk($sformatf("vec%0d_time", i), dut_time(), vecs[i].exp_time);
            chk($sformatf("vec%0d_blank", i), int'(o_blank), int'(vecs[i].exp_blank));
        end

        // Full carry chain: 23:59:59.99 -> 00:00:00.00 on a single tick.
        repeat (10) cycle(3'b100, 1'b1, 1'b0);
        chk("preload_set", dut_time(), 23595900);
        cycle(3'b000, 1'b0, 1'b0);
        chk("resume_clear", dut_time(), 23595900);
        repeat (396) cycle(3'b000, 1'b0, 1'b0);
        chk("last_csec", dut_time(), 23595999);
        repeat (3) cycle(3'b000, 1'b0, 1'b0);
        chk("hold_before_wrap", dut_time(), 23595999);
        cycle(3'b000, 1'b0, 1'b0);
        chk("midnight_wrap", dut_time(), 0);

        cycle(3'b101, 1'b0, 1'b1);
        chk("hour_down_wrap", dut_time(), 23000000);
        cycle(3'b101, 1'b1, 1'b1);
        chk("up_down_together", dut_time(), 23000000);

        repeat (40) cycle(3'b000, 1'b0, 1'b0);
        chk("run_40", dut_time(), 23000009);

        // Blink phase in SET, edit forcing visible, and csec clearing on return to RUN.
        for (int n = 1; n <= 12; n++) begin
            cycle(3'b001, 1'b0, 1'b0);
            if (n == 7)  chk("blink_n7", int'(o_blank), 0);
            if (n == 8)  chk("blink_n8", int'(o_blank), 1);
            if (n == 12) begin
                chk("blink_n12", int'(o_blank), 1);
                chk("set_holds_csec", dut_time(), 23000009);
            end
        end
        cycle(3'b001, 1'b1, 1'b0);
        chk("edit_unblank", int'(o_blank), 0);
        chk("edit_sec_up", dut_time(), 23000109);
        cycle(3'b000, 1'b0, 1'b0);
        chk("drop_set_time", dut_time(), 23000100);
        chk("drop_set_blank", int'(o_blank), 0);

        // Asynchronous reset mid-SET.
        apply_reset();
        repeat (7)  cycle(3'b100, 1'b0, 1'b1);
        repeat (17) cycle(3'b010, 1'b1, 1'b0);
        repeat (33) cycle(3'b001, 1'b1, 1'b0);
        chk("preset_051733", dut_time(), 5173300);
        repeat (8) cycle(3'b001, 1'b0, 1'b0);
        chk("preset_blank", int'(o_blank), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_time", dut_time(), 12000000);
        chk("async_rst_blank", int'(o_blank), 0);
        apply_reset();

        for (int seg = 0; seg < 70; seg++) begin
            rsel = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            rlen = $urandom_range(1, 60);
            for (int k = 0; k < rlen; k++)
                cycle(rsel, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
